// File: rtl/grade_rank_pkg.sv
//------------------------------------------------------------------------------
// grade_rank_pkg
//   Shared FSM state type and option-bit positions for the grade ranking block.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package grade_rank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int c_opt_signed = 0;
  localparam int c_opt_desc   = 1;
  localparam int c_opt_ncnt   = 2;

endpackage

`default_nettype wire

// File: rtl/grade_rank_cmp.sv
//------------------------------------------------------------------------------
// grade_rank_cmp
//   Insert-before test for one sorted slot: high when the new score must be
//   placed ahead of the slot's score (strict compare keeps ties stable).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module grade_rank_cmp
  import grade_rank_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_new,
  input  logic [W-1:0] i_old,
  input  logic         i_signed,
  input  logic         i_desc,
  output logic         o_ins
);

  logic w_lt;
  logic w_gt;

  always_comb begin
    if (i_signed) begin
      w_lt = $signed(i_new) < $signed(i_old);
      w_gt = $signed(i_new) > $signed(i_old);
    end else begin
      w_lt = i_new < i_old;
      w_gt = i_new > i_old;
    end
    o_ins = i_desc ? w_gt : w_lt;
  end

endmodule

`default_nettype wire

// File: rtl/grade_rank_seq.sv
//------------------------------------------------------------------------------
// grade_rank_seq
//   Loads N scores into an insertion-sorted array, computes a pass threshold
//   from the batch average, then streams sorted IDs with the pass count.
//   Optional out_pass port: define GRADE_RANK_PASS_FLAG_EN.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module grade_rank_seq
  import grade_rank_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_score,
  input  logic [2:0]                 opt,
  input  logic [1:0]                 a,
  input  logic [2:0]                 b,
  output logic                       out_valid,
  output logic [$clog2(N)-1:0]       out_id,
  output logic [$clog2(N+1)-1:0]     out_cnt
`ifdef GRADE_RANK_PASS_FLAG_EN
  ,
  output logic                       out_pass
`endif
);

  localparam int c_iw = $clog2(N);
  localparam int c_cw = $clog2(N+1);
  localparam int c_sw = W + $clog2(N) + 1;
  // Threshold math headroom: (t-a)*(a+1) grows by up to a few bits over avg.
  localparam int c_tw = c_sw + 4;

  localparam logic signed [c_sw-1:0] c_n_s = c_sw'(N);
  localparam logic signed [c_tw-1:0] c_one = c_tw'(1);

  function automatic logic signed [c_tw-1:0] f_ext(input logic [W-1:0] s, input logic sg);
    logic signed [c_tw-1:0] v;
    if (sg) v = c_tw'($signed(s));
    else    v = c_tw'(s);
    return v;
  endfunction

  state_t                   r_state;
  logic [W-1:0]             r_score [N];
  logic [c_iw-1:0]          r_id    [N];
  logic [c_cw-1:0]          r_n;
  logic [c_cw-1:0]          r_idx;
  logic signed [c_sw-1:0]   r_sum;
  logic [2:0]               r_opt;
  logic [1:0]               r_a;
  logic [2:0]               r_b;
`ifdef GRADE_RANK_PASS_FLAG_EN
  logic [N-1:0]             r_pass;
`endif

  logic                     w_take;
  logic [2:0]               w_opt;
  logic [c_iw-1:0]          w_new_id;
  logic signed [c_tw-1:0]   w_in_ext;
  logic [N-1:0]             w_cmp;
  logic [N-1:0]             w_ins;
  logic [W-1:0]             w_nxt_score [N];
  logic [c_iw-1:0]          w_nxt_id    [N];
  logic [N-1:0]             w_pass;
  logic [c_cw-1:0]          w_cnt;
  logic [c_cw-1:0]          w_cnt_out;
  logic signed [c_sw-1:0]   w_avg;
  logic signed [c_tw-1:0]   w_a;
  logic signed [c_tw-1:0]   w_a1;
  logic signed [c_tw-1:0]   w_b;
  logic signed [c_tw-1:0]   w_t;
  logic signed [c_tw-1:0]   w_thr_n;
  logic signed [c_tw-1:0]   w_thr_p;

  // The first beat arrives in IDLE, before opt has been latched.
  assign w_opt    = (r_state == IDLE) ? opt : r_opt;
  assign w_take   = in_valid && ((r_state == IDLE) || (r_state == LOAD));
  assign w_new_id = r_n[c_iw-1:0];
  assign w_in_ext = f_ext(in_score, w_opt[c_opt_signed]);

  assign w_avg   = r_sum / c_n_s;
  assign w_a     = {{(c_tw-2){1'b0}}, r_a};
  assign w_a1    = w_a + c_one;
  assign w_b     = {{(c_tw-3){1'b0}}, r_b};
  assign w_t     = c_tw'(w_avg) - w_b;
  assign w_thr_n = (w_t - w_a) * w_a1 - w_a;
  assign w_thr_p = w_t / w_a1;

  for (genvar k = 0; k < N; k++) begin : g_slot
    grade_rank_cmp #(.W(W)) u_cmp (
      .i_new    (in_score),
      .i_old    (r_score[k]),
      .i_signed (w_opt[c_opt_signed]),
      .i_desc   (w_opt[c_opt_desc]),
      .o_ins    (w_cmp[k])
    );

    // Empty slots always accept, so the new entry lands at the first
    // position whose occupant it beats, or at the end of the filled run.
    assign w_ins[k] = (r_n <= c_cw'(k)) | w_cmp[k];

    if (k == 0) begin : g_head
      assign w_nxt_score[k] = w_ins[k] ? in_score : r_score[k];
      assign w_nxt_id[k]    = w_ins[k] ? w_new_id : r_id[k];
    end else begin : g_body
      assign w_nxt_score[k] = !w_ins[k] ? r_score[k] : (w_ins[k-1] ? r_score[k-1] : in_score);
      assign w_nxt_id[k]    = !w_ins[k] ? r_id[k]    : (w_ins[k-1] ? r_id[k-1]    : w_new_id);
    end

    assign w_pass[k] = f_ext(r_score[k], r_opt[c_opt_signed]) >=
                       ((r_opt[c_opt_signed] && r_score[k][W-1]) ? w_thr_n : w_thr_p);
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < N; k++) begin
      w_cnt = w_cnt + c_cw'(w_pass[k]);
    end
    w_cnt_out = r_opt[c_opt_ncnt] ? (c_cw'(N) - w_cnt) : w_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_opt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_cnt   <= '0;
      for (int k = 0; k < N; k++) begin
        r_score[k] <= '0;
        r_id[k]    <= '0;
      end
`ifdef GRADE_RANK_PASS_FLAG_EN
      r_pass    <= '0;
      out_pass  <= 1'b0;
`endif
    end else begin
      if (w_take) begin
        for (int k = 0; k < N; k++) begin
          r_score[k] <= w_nxt_score[k];
          r_id[k]    <= w_nxt_id[k];
        end
      end

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opt   <= opt;
            r_a     <= a;
            r_b     <= b;
            r_sum   <= w_in_ext[c_sw-1:0];
            r_n     <= c_cw'(1);
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r_sum <= r_sum + w_in_ext[c_sw-1:0];
            r_n   <= r_n + c_cw'(1);
            if (r_n == c_cw'(N-1)) begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          out_valid <= 1'b1;
          out_id    <= r_id[0];
          out_cnt   <= w_cnt_out;
          r_idx     <= c_cw'(1);
          r_n       <= '0;
          r_state   <= OUT;
`ifdef GRADE_RANK_PASS_FLAG_EN
          r_pass    <= w_pass;
          out_pass  <= w_pass[0];
`endif
        end
        OUT: begin
          if (r_idx == c_cw'(N)) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_cnt   <= '0;
            r_idx     <= '0;
            r_state   <= IDLE;
`ifdef GRADE_RANK_PASS_FLAG_EN
            out_pass  <= 1'b0;
`endif
          end else begin
            out_id <= r_id[r_idx[c_iw-1:0]];
            r_idx  <= r_idx + c_cw'(1);
`ifdef GRADE_RANK_PASS_FLAG_EN
            out_pass <= r_pass[r_idx[c_iw-1:0]];
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/grade_rank_seq.md
GRADE_RANK_SEQ -- requirements
Module: grade_rank_seq

Interface
REQ-001 SHALL have parameter N, default 7, the number of students per batch (2..16).
REQ-002 SHALL have parameter W, default 4, the score width in bits (3..8).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, qualifying one score per cycle.
REQ-006 SHALL have port in_score, input, W bits, the score; student ID = arrival index 0..N-1.
REQ-007 SHALL have port opt, input, 3 bits: [0]=signed scores, [1]=descending, [2]=report N-count; sampled with the first score only.
REQ-008 SHALL have ports a (input, 2 bits) and b (input, 3 bits), the unsigned threshold parameters; sampled with the first score only.
REQ-009 SHALL have port out_valid, output, 1 bit, qualifying result beats.
REQ-010 SHALL have port out_id, output, clog2(N) bits, one student ID per beat in sorted order.
REQ-011 SHALL have port out_cnt, output, clog2(N+1) bits, the pass count, held constant across all beats of a batch.

Function
REQ-012 SHALL use FSM states IDLE -> LOAD -> CALC -> OUT -> IDLE.
REQ-013 SHALL leave IDLE for LOAD on the first in_valid beat; that beat is stored as ID 0.
REQ-014 SHALL, in LOAD, insert each valid score into a sorted register array in the same cycle (parallel compare and shift), with one entry per cycle.
REQ-015 SHALL hold the LOAD state, with no ID advance, on a cycle where in_valid is low; the batch completes on the Nth valid beat.
REQ-016 SHALL compare scores as two's complement when opt[0]=1 and unsigned otherwise.
REQ-017 SHALL break ties stably: for equal scores the lower ID precedes, in both ascending and descending order.
REQ-018 SHALL accumulate a signed sum during LOAD, sized W+clog2(N)+1 bits.
REQ-019 SHALL compute, in the single CALC cycle: avg = sum/N, truncated toward zero.
REQ-020 SHALL compute, in the same CALC cycle: t = avg-b; thrN = (t-a)*(a+1)-a; thrP = t/(a+1), truncated toward zero; all signed.
REQ-021 SHALL count a student as passing when score >= thr (signed compare).
REQ-022 SHALL take thr = thrN for a score whose sign bit is set and opt[0]=1; thr = thrP otherwise.
REQ-023 SHALL set out_cnt = count when opt[2]=0, and N-count when opt[2]=1.
REQ-024 SHALL enter OUT the cycle after CALC and assert out_valid for exactly N consecutive cycles.
REQ-025 SHALL place the first out_valid beat 2 cycles after the last in_valid beat.
REQ-026 SHALL return to IDLE after the Nth output beat.
REQ-027 SHALL drive out_id=0 and out_cnt=0 whenever out_valid=0.
REQ-028 SHALL ignore in_valid during CALC and OUT.
REQ-029 SHALL accept a new batch starting on the cycle after the last OUT beat.

Reset
REQ-030 SHALL, on rst asserted (asynchronously, including mid-LOAD or mid-OUT), go to IDLE with out_valid=0, out_id=0 and out_cnt=0, and clear the sum, the entry counter and the latched opt/a/b.
REQ-031 SHALL discard any partial batch on rst.

Configuration
REQ-032 SHALL, with GRADE_RANK_PASS_FLAG_EN defined, add an output out_pass, 1 bit, set on each beat when the student being output passed (0 when out_valid=0).
REQ-033 SHALL, without GRADE_RANK_PASS_FLAG_EN, omit the out_pass port and its per-entry pass logic.

Structure
REQ-034 SHALL place the FSM state enum and the opt bit-index constants in shared package grade_rank_pkg.
REQ-035 SHALL use one sub-module, grade_rank_cmp: a combinational signed/unsigned, asc/desc "insert-before" comparator instantiated per array slot.

Verification
REQ-036 SHALL check, with N=7, W=4, opt=000, a=0, b=0 and scores 3,9,1,9,0,15,5: out_id 4,2,0,6,1,3,5; out_cnt=3 (avg 6, thr 6).
REQ-037 SHALL check the same scores with opt=110: out_id 5,1,3,6,0,2,4; out_cnt=4.
REQ-038 SHALL check opt=001, a=1, b=0, scores F,8,2,3,0,0,0 (sum -4, avg 0, thrN -3, thrP 0): out_id 1,0,4,5,6,2,3; out_cnt=6.
REQ-039 SHALL check a batch with in_valid gaps of 1-3 cycles between beats: results identical to the gapless run, with the first out_valid exactly 2 cycles after the last valid beat.
REQ-040 SHALL check rst pulsed at the 4th LOAD beat, then a full new batch: outputs zero during reset, new batch correct, no residue from the aborted batch.
REQ-041 SHALL check back-to-back batches, the second starting the cycle after the last OUT beat: both correct, and out_pass matches pass status when GRADE_RANK_PASS_FLAG_EN is defined.
